if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 9 +
 rtl/if_fetch.sv | 125 ++++++++++++
 tb/tb_if_fetch.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared hold levels, NOP encoding and fetch FSM state encodings
package if_fetch_pkg;
    localparam logic [2:0] Hold_None = 3'b000;
    localparam logic [2:0] Hold_Pc   = 3'b001;
    localparam logic [2:0] Hold_If   = 3'b010;
    localparam logic [2:0] Hold_Id   = 3'b011;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} fetch_state_t;
endpackage

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch with redirect kill; IF_FETCH_SKID_EN adds a hold skid buffer
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] INST_NOP_VAL = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o
);
    fetch_state_t r_state, w_state_nxt;
    logic [31:0]  r_pc, w_pc_nxt, r_addr, r_jtgt, w_jtgt_nxt, r_inst_addr;
    logic         r_kill, w_kill_nxt, r_pres;
    logic         w_hold, w_gnt, w_rsp, w_live, w_bus_dlv, w_skid_full, w_skid_dlv, w_drop;
    logic [31:0]  w_skid_data, w_skid_addr;

    assign w_hold      = hold_flag_i >= Hold_Pc;
    // a request already on the bus stays up through hold until granted
    assign ibus_req_o  = (r_state == REQ) && !w_skid_full && (!w_hold || r_pres);
    assign ibus_addr_o = r_pc;
    assign w_gnt       = ibus_req_o && ibus_gnt_i;
    assign w_rsp       = (r_state == WAIT) && ibus_rvalid_i;
    // a response still on the program path: not killed and not overtaken by a redirect this cycle
    assign w_live      = w_rsp && !r_kill && !jump_flag_i;
    assign w_bus_dlv   = w_live && !w_hold;

`ifdef IF_FETCH_SKID_EN
    logic        r_skid_v;
    logic [31:0] r_skid_data, r_skid_addr;
    assign w_skid_full = r_skid_v;
    assign w_skid_dlv  = r_skid_v && !w_hold && !jump_flag_i;
    assign w_skid_data = r_skid_data;
    assign w_skid_addr = r_skid_addr;
    assign w_drop      = 1'b0;
    // park a response that arrives during hold; a redirect or the release delivery empties it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_skid_v    <= 1'b0;
            r_skid_data <= '0;
            r_skid_addr <= '0;
        end else if (jump_flag_i || w_skid_dlv) begin
            r_skid_v <= 1'b0;
        end else if (w_live && w_hold) begin
            r_skid_v    <= 1'b1;
            r_skid_data <= ibus_rdata_i;
            r_skid_addr <= r_addr;
        end
    end
`else
    assign w_skid_full = 1'b0;
    assign w_skid_dlv  = 1'b0;
    assign w_skid_data = '0;
    assign w_skid_addr = '0;
    assign w_drop      = w_live && w_hold;
`endif

    assign inst_valid_o = w_bus_dlv || w_skid_dlv;
    assign inst_o       = w_bus_dlv ? ibus_rdata_i : w_skid_dlv ? w_skid_data : INST_NOP_VAL;
    assign inst_addr_o  = w_bus_dlv ? r_addr : w_skid_dlv ? w_skid_addr : r_inst_addr;

    // next state, pc and kill; a redirect overrides everything and a pending one is held until grant
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_kill_nxt  = r_kill;
        w_jtgt_nxt  = r_jtgt;
        case (r_state)
            IDLE:    w_state_nxt = w_hold ? IDLE : REQ;
            REQ: if (w_gnt) begin
                w_state_nxt = WAIT;
                w_pc_nxt    = r_kill ? r_jtgt : r_pc + 32'd4;
            end
            WAIT: if (w_rsp) begin
                w_state_nxt = REQ;
                w_kill_nxt  = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_drop)
            w_pc_nxt = r_addr;
        if (jump_flag_i) begin
            if (ibus_req_o && !ibus_gnt_i) begin
                w_kill_nxt = 1'b1;
                w_jtgt_nxt = jump_addr_i;
            end else begin
                w_pc_nxt   = jump_addr_i;
                w_kill_nxt = w_gnt || ((r_state == WAIT) && !ibus_rvalid_i);
            end
        end
    end

    // state register plus granted address and last delivered address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_jtgt      <= '0;
            r_pres      <= 1'b0;
            r_addr      <= '0;
            r_inst_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_kill  <= w_kill_nxt;
            r_jtgt  <= w_jtgt_nxt;
            r_pres  <= ibus_req_o && !ibus_gnt_i;
            if (w_gnt)
                r_addr <= r_pc;
            if (inst_valid_o)
                r_inst_addr <= inst_addr_o;
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a program-order delivery model and bus rule checks
module tb_if_fetch;
    import if_fetch_pkg::*;

    logic        clk = 1'b0, rst = 1'b0, jump_flag_i = 1'b0, ibus_gnt_i = 1'b0, ibus_rvalid_i = 1'b0;
    logic [31:0] jump_addr_i = '0, ibus_rdata_i = '0;
    logic [2:0]  hold_flag_i = '0;
    logic        ibus_req_o, inst_valid_o;
    logic [31:0] ibus_addr_o, inst_o, inst_addr_o;
    int          errors = 0, checks = 0;
    int          gnt_delay = 0, rsp_delay = 1;

    always #5 clk = ~clk;

    if_fetch dut (
        .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_flag_i(hold_flag_i), .ibus_req_o(ibus_req_o), .ibus_addr_o(ibus_addr_o),
        .ibus_gnt_i(ibus_gnt_i), .ibus_rvalid_i(ibus_rvalid_i), .ibus_rdata_i(ibus_rdata_i),
        .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : {a[15:0] ^ 16'hBEEF, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // kind: 0 req, 1 req+gnt, 2 inst_valid, 3 rvalid, 4 req at address a
    task automatic wait_for(input string name, input int kind, input logic [31:0] a);
        bit hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk); #3;
            hit = kind == 0 ? ibus_req_o : kind == 1 ? (ibus_req_o && ibus_gnt_i) :
                  kind == 2 ? inst_valid_o : kind == 3 ? ibus_rvalid_i :
                  (ibus_req_o && ibus_addr_o == a);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: got no event expected one within 60 cycles", name);
        end
    endtask

    // bus slave: grant after gnt_delay request cycles, answer rsp_delay cycles after grant
    initial begin : responder
        int gw, rc;
        bit pend;
        logic [31:0] pa;
        gw = 0; rc = 0; pend = 1'b0; pa = '0;
        forever begin
            @(posedge clk); #2;
            ibus_gnt_i = 1'b0;
            ibus_rvalid_i = 1'b0;
            if (!rst) begin
                pend = 1'b0;
                gw = 0;
            end else begin
                if (pend) begin
                    if (rc == 0) begin
                        ibus_rvalid_i = 1'b1;
                        ibus_rdata_i = mem(pa);
                        pend = 1'b0;
                    end else rc--;
                end
                if (ibus_req_o) begin
                    if (gw >= gnt_delay) begin
                        ibus_gnt_i = 1'b1;
                        pend = 1'b1;
                        pa = ibus_addr_o;
                        rc = rsp_delay - 1;
                        gw = 0;
                    end else gw++;
                end
            end
        end
    end

    // model: deliveries follow program order from RESET_PC, redirected by jumps; bus handshake rules
    initial begin : model
        logic [31:0] exp_next, last_addr, prev_addr;
        bit prev_pend;
        int n_out;
        exp_next = '0; last_addr = '0; prev_addr = '0; prev_pend = 1'b0; n_out = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_req", 32'(ibus_req_o), 32'd0);
                chk("rst_ibus_addr", ibus_addr_o, 32'h0);
                chk("rst_valid", 32'(inst_valid_o), 32'd0);
                chk("rst_inst", inst_o, INST_NOP);
                chk("rst_inst_addr", inst_addr_o, 32'h0);
                exp_next = '0; last_addr = '0; prev_pend = 1'b0; n_out = 0;
            end else begin
                if (prev_pend) begin
                    chk("req_stable", 32'(ibus_req_o), 32'd1);
                    chk("addr_stable", ibus_addr_o, prev_addr);
                end
                if (n_out > 0)
                    chk("one_outstanding", 32'(ibus_req_o), 32'd0);
                if (inst_valid_o) begin
                    chk("dlv_addr", inst_addr_o, exp_next);
                    chk("dlv_data", inst_o, mem(inst_addr_o));
                    chk("dlv_no_hold", 32'(hold_flag_i < Hold_Pc), 32'd1);
                    last_addr = inst_addr_o;
                    exp_next = inst_addr_o + 32'd4;
                end else begin
                    chk("nop_inst", inst_o, INST_NOP);
                    chk("nop_addr_keep", inst_addr_o, last_addr);
                end
                if (jump_flag_i)
                    exp_next = jump_addr_i;
                n_out = n_out + int'(ibus_req_o && ibus_gnt_i) - int'(ibus_rvalid_i);
                prev_pend = ibus_req_o && !ibus_gnt_i;
                prev_addr = ibus_addr_o;
            end
        end
    end

    initial begin
        logic [31:0] a;
        repeat (2) @(posedge clk);
        #3;
        chk("reset_req", 32'(ibus_req_o), 32'd0);
        chk("reset_valid", 32'(inst_valid_o), 32'd0);
        chk("reset_inst", inst_o, 32'h0000_0013);
        // first fetch: IDLE, REQ with grant, delivery at cycle 2
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #3;
        chk("c1_req", 32'(ibus_req_o), 32'd1);
        chk("c1_addr", ibus_addr_o, 32'h0);
        @(posedge clk); #3;
        chk("c2_valid", 32'(inst_valid_o), 32'd1);
        chk("c2_inst_addr", inst_addr_o, 32'h0);
        chk("c2_inst", inst_o, 32'h0050_0093);
        @(posedge clk); #3;
        chk("c3_req", 32'(ibus_req_o), 32'd1);
        chk("c3_addr", ibus_addr_o, 32'h4);
        // grant delayed 3 cycles at 0x8
        gnt_delay = 3;
        wait_for("req_0x8", 4, 32'h8);
        repeat (3) begin
            @(posedge clk); #3;
            chk("slow_gnt_req", 32'(ibus_req_o), 32'd1);
            chk("slow_gnt_addr", ibus_addr_o, 32'h8);
        end
        gnt_delay = 0;
        wait_for("dlv_0x8", 2, '0);
        chk("slow_gnt_dlv", inst_addr_o, 32'h8);
        // jump in WAIT to 0x100
        rsp_delay = 3;
        wait_for("gnt_0xc", 1, '0);
        @(posedge clk); #1; jump_flag_i = 1'b1; jump_addr_i = 32'h100;
        #2 chk("wait_no_req", 32'(ibus_req_o), 32'd0);
        @(posedge clk); #1; jump_flag_i = 1'b0;
        wait_for("killed_rsp", 3, '0);
        chk("killed_valid", 32'(inst_valid_o), 32'd0);
        @(posedge clk); #3;
        chk("jump_req", 32'(ibus_req_o), 32'd1);
        chk("jump_addr", ibus_addr_o, 32'h100);
        rsp_delay = 1;
        wait_for("dlv_0x100", 2, '0);
        chk("jump_dlv", inst_addr_o, 32'h100);
        // jump while a request waits for grant
        gnt_delay = 2;
        wait_for("req_ungranted", 0, '0);
        a = ibus_addr_o;
        @(posedge clk); #1; jump_flag_i = 1'b1; jump_addr_i = 32'h200;
        #2 chk("defer_addr_a", ibus_addr_o, a);
        @(posedge clk); #1; jump_flag_i = 1'b0;
        #2 chk("defer_addr_b", ibus_addr_o, a);
        chk("defer_req", 32'(ibus_req_o), 32'd1);
        gnt_delay = 0;
        wait_for("req_0x200", 4, 32'h200);
        wait_for("dlv_0x200", 2, '0);
        chk("defer_dlv", inst_addr_o, 32'h200);
        // address wrap
        wait_for("gnt_0x204", 1, '0);
        @(posedge clk); #1; jump_flag_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        @(posedge clk); #1; jump_flag_i = 1'b0;
        #2 chk("top_addr", ibus_addr_o, 32'hFFFF_FFFC);
        wait_for("dlv_top", 2, '0);
        chk("top_dlv", inst_addr_o, 32'hFFFF_FFFC);
        @(posedge clk); #3;
        chk("wrap_req", 32'(ibus_req_o), 32'd1);
        chk("wrap_addr", ibus_addr_o, 32'h0);
        // response at 0x10 arriving under Hold_Id
        @(posedge clk); #1; jump_flag_i = 1'b1; jump_addr_i = 32'h10; rsp_delay = 2;
        @(posedge clk); #1; jump_flag_i = 1'b0;
        #2 chk("hold_req_addr", ibus_addr_o, 32'h10);
        chk("hold_req", 32'(ibus_req_o), 32'd1);
        @(posedge clk);
        @(posedge clk); #1; hold_flag_i = Hold_Id;
        #2 chk("hold_rsp_valid", 32'(inst_valid_o), 32'd0);
        repeat (2) begin
            @(posedge clk); #3;
            chk("hold_no_req", 32'(ibus_req_o), 32'd0);
        end
        @(posedge clk); #1; hold_flag_i = Hold_None; rsp_delay = 1;
`ifdef IF_FETCH_SKID_EN
        #2 chk("skid_valid", 32'(inst_valid_o), 32'd1);
        chk("skid_addr", inst_addr_o, 32'h10);
        chk("skid_no_req", 32'(ibus_req_o), 32'd0);
        @(posedge clk); #3;
        chk("skid_next_addr", ibus_addr_o, 32'h14);
`else
        #2 chk("refetch_req", 32'(ibus_req_o), 32'd1);
        chk("refetch_addr", ibus_addr_o, 32'h10);
        wait_for("dlv_refetch", 2, '0);
        chk("refetch_dlv", inst_addr_o, 32'h10);
`endif
        // hold does not retract a request already on the bus
        gnt_delay = 2;
        wait_for("req_before_hold", 0, '0);
        a = ibus_addr_o;
        @(posedge clk); #1; hold_flag_i = Hold_Id;
        #2 chk("held_req", 32'(ibus_req_o), 32'd1);
        @(posedge clk); #3;
        chk("held_req2", 32'(ibus_req_o), 32'd1);
        chk("held_addr", ibus_addr_o, a);
        @(posedge clk); #1; hold_flag_i = Hold_None; gnt_delay = 0;
        #2 chk("held_dlv_addr", inst_addr_o, a);
        // reset while WAIT
        rsp_delay = 3;
        wait_for("gnt_before_rst", 1, '0);
        @(posedge clk); #1; rst = 1'b0;
        #2 chk("wait_rst_req", 32'(ibus_req_o), 32'd0);
        chk("wait_rst_inst_addr", inst_addr_o, 32'h0);
        @(posedge clk); #1; rst = 1'b1; rsp_delay = 1;
        wait_for("req_after_rst", 0, '0);
        chk("after_rst_addr", ibus_addr_o, 32'h0);
        wait_for("dlv_after_rst", 2, '0);
        chk("after_rst_dlv", inst_addr_o, 32'h0);
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
